// File: rtl/mini_sysarray_sched.sv
// Tile scheduler for a 2x2-output systolic array: walks output tiles row-major,
// runs K chunks per tile, accumulates with saturation and hands off finished tiles.
module mini_sysarray_sched #(
    parameter int WIDTH    = 8,
    parameter int ACC_W    = 20,
    parameter int M_TILES  = 4,
    parameter int N_TILES  = 4,
    parameter int K_CHUNKS = 4,
    parameter int IDX_W    = 4
) (
    input  logic                        clk,
    input  logic                        _reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        cal_importance,
    output logic                        busy,
    output logic                        done,
    output logic                        tile_req,
    output logic [IDX_W-1:0]            tile_row,
    output logic [IDX_W-1:0]            tile_col,
    output logic [IDX_W-1:0]            tile_k,
    input  logic                        tile_ack,
    output logic                        sa_enable,
    output logic                        sa_cal_importance,
    input  logic                        sa_done,
    input  logic signed [2*WIDTH-1:0]   sa_result0,
    input  logic signed [2*WIDTH-1:0]   sa_result1,
    input  logic signed [2*WIDTH-1:0]   sa_result2,
    input  logic signed [2*WIDTH-1:0]   sa_result3,
    input  logic [2*WIDTH-1:0]          sa_importance,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_row,
    output logic [IDX_W-1:0]            out_col,
    output logic signed [ACC_W-1:0]     out_c00,
    output logic signed [ACC_W-1:0]     out_c01,
    output logic signed [ACC_W-1:0]     out_c10,
    output logic signed [ACC_W-1:0]     out_c11,
    output logic [2*WIDTH-1:0]          out_importance
);
    localparam int RW = 2 * WIDTH;
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(K_CHUNKS - 1);
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(N_TILES - 1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(M_TILES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RUN, S_ACC, S_OUT, S_FIN
    } state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  row_reg, col_reg, k_reg;
    logic              imp_en_reg;
    logic [RW-1:0]     imp_reg;

    logic signed [RW-1:0]    result_in [4];
    logic signed [RW-1:0]    hold_reg  [4];
    logic signed [ACC_W-1:0] acc_reg   [4];

    logic last_chunk, last_tile, abort_hit, start_hit, xfer, acc_clear;

    assign last_chunk = (k_reg == K_LAST);
    assign last_tile  = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    assign abort_hit  = abort && (state_reg != S_IDLE);
    assign start_hit  = start && (state_reg == S_IDLE);
    assign xfer       = (state_reg == S_OUT) && out_ready && !abort;
    assign acc_clear  = abort_hit || start_hit || xfer;

    assign result_in[0] = sa_result0;
    assign result_in[1] = sa_result1;
    assign result_in[2] = sa_result2;
    assign result_in[3] = sa_result3;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        busy              = 1'b0;
        done              = 1'b0;
        tile_req          = 1'b0;
        sa_enable         = 1'b0;
        sa_cal_importance = 1'b0;
        out_valid         = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_REQ;
            end
            S_REQ: begin
                busy     = 1'b1;
                tile_req = 1'b1;
                if (tile_ack) state_next = S_RUN;
            end
            S_RUN: begin
                busy              = 1'b1;
                sa_enable         = 1'b1;
                sa_cal_importance = imp_en_reg && last_chunk;
                if (sa_done) state_next = S_ACC;
            end
            S_ACC: begin
                busy       = 1'b1;
                state_next = last_chunk ? S_OUT : S_REQ;
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = last_tile ? S_FIN : S_REQ;
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort_hit) state_next = S_IDLE;
    end

    // Indices and Importance; indices return to 0 after the final tile and on abort.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            row_reg    <= '0;
            col_reg    <= '0;
            k_reg      <= '0;
            imp_en_reg <= 1'b0;
            imp_reg    <= '0;
        end else if (abort_hit) begin
            row_reg    <= '0;
            col_reg    <= '0;
            k_reg      <= '0;
            imp_en_reg <= 1'b0;
            imp_reg    <= '0;
        end else if (start_hit) begin
            row_reg    <= '0;
            col_reg    <= '0;
            k_reg      <= '0;
            imp_en_reg <= cal_importance;
            imp_reg    <= '0;
        end else if (state_reg == S_ACC) begin
            if (imp_en_reg && last_chunk) imp_reg <= sa_importance;
            if (!last_chunk) k_reg <= k_reg + IDX_W'(1);
        end else if (xfer) begin
            k_reg   <= '0;
            imp_reg <= '0;
            if (last_tile) begin
                row_reg <= '0;
                col_reg <= '0;
            end else if (col_reg == COL_LAST) begin
                col_reg <= '0;
                row_reg <= row_reg + IDX_W'(1);
            end else begin
                col_reg <= col_reg + IDX_W'(1);
            end
        end
    end

    // Per-lane result capture and saturating accumulation; overflow shows as a
    // disagreement between the two top bits of the one-bit-wider sum.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic signed [ACC_W:0] sum_ext;
            assign sum_ext = {acc_reg[gi][ACC_W-1], acc_reg[gi]}
                           + {{(ACC_W + 1 - RW){hold_reg[gi][RW-1]}}, hold_reg[gi]};

            always_ff @(posedge clk or negedge _reset) begin
                if (!_reset) begin
                    hold_reg[gi] <= '0;
                end else if ((state_reg == S_RUN) && sa_done && !abort) begin
                    hold_reg[gi] <= result_in[gi];
                end
            end

            always_ff @(posedge clk or negedge _reset) begin
                if (!_reset) begin
                    acc_reg[gi] <= '0;
                end else if (acc_clear) begin
                    acc_reg[gi] <= '0;
                end else if (state_reg == S_ACC) begin
                    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                        acc_reg[gi] <= sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                      : {1'b0, {(ACC_W-1){1'b1}}};
                    end else begin
                        acc_reg[gi] <= sum_ext[ACC_W-1:0];
                    end
                end
            end
        end
    endgenerate

    assign tile_row       = row_reg;
    assign tile_col       = col_reg;
    assign tile_k         = k_reg;
    assign out_row        = row_reg;
    assign out_col        = col_reg;
    assign out_c00        = acc_reg[0];
    assign out_c01        = acc_reg[1];
    assign out_c10        = acc_reg[2];
    assign out_c11        = acc_reg[3];
    assign out_importance = imp_reg;

endmodule

// File: tb/tb_mini_sysarray_sched.sv
// Bench for mini_sysarray_sched: plays operand buffer, array and downstream sink,
// and checks tiles against a saturating-sum model of the job.
module tb_mini_sysarray_sched;
    localparam int WIDTH    = 8;
    localparam int ACC_W    = 16;
    localparam int M_TILES  = 2;
    localparam int N_TILES  = 2;
    localparam int K_CHUNKS = 4;
    localparam int IDX_W    = 4;
    localparam int RW       = 2 * WIDTH;
    localparam int ACC_MAX  = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN  = -(1 << (ACC_W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, cal_importance = 1'b0;
    logic busy, done, tile_req;
    logic [IDX_W-1:0] tile_row, tile_col, tile_k;
    logic tile_ack = 1'b0;
    logic sa_enable, sa_cal_importance;
    logic sa_done = 1'b0;
    logic signed [RW-1:0] sa_result0 = '0, sa_result1 = '0, sa_result2 = '0, sa_result3 = '0;
    logic [RW-1:0] sa_importance = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [IDX_W-1:0] out_row, out_col;
    logic signed [ACC_W-1:0] out_c00, out_c01, out_c10, out_c11;
    logic [RW-1:0] out_importance;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mini_sysarray_sched #(
        .WIDTH(WIDTH), .ACC_W(ACC_W), .M_TILES(M_TILES), .N_TILES(N_TILES),
        .K_CHUNKS(K_CHUNKS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), ._reset(rst_n), .start(start), .abort(abort),
        .cal_importance(cal_importance), .busy(busy), .done(done),
        .tile_req(tile_req), .tile_row(tile_row), .tile_col(tile_col), .tile_k(tile_k),
        .tile_ack(tile_ack), .sa_enable(sa_enable), .sa_cal_importance(sa_cal_importance),
        .sa_done(sa_done), .sa_result0(sa_result0), .sa_result1(sa_result1),
        .sa_result2(sa_result2), .sa_result3(sa_result3), .sa_importance(sa_importance),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_c00(out_c00), .out_c01(out_c01), .out_c10(out_c10), .out_c11(out_c11),
        .out_importance(out_importance)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    function automatic int gen(input int mode, input int k, input int lane);
        int d1 [4];
        int d3 [4];
        d1 = '{16000, -16000, 1000, -250};
        d3 = '{3, -5, 7, 100};
        case (mode)
            1:       return d1[lane];
            2:       return int'($urandom_range(0, 1000)) - 500;
            3:       return (k == 0) ? d3[lane] : 0;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic chk_idle(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_tile_req"}, tile_req, 0);
        chk({pfx, "_tile_row"}, tile_row, 0);
        chk({pfx, "_tile_col"}, tile_col, 0);
        chk({pfx, "_tile_k"}, tile_k, 0);
        chk({pfx, "_sa_enable"}, sa_enable, 0);
        chk({pfx, "_sa_cal_imp"}, sa_cal_importance, 0);
        chk({pfx, "_out_valid"}, out_valid, 0);
        chk({pfx, "_out_row"}, out_row, 0);
        chk({pfx, "_out_col"}, out_col, 0);
        chk({pfx, "_c00"}, out_c00, 0);
        chk({pfx, "_c01"}, out_c01, 0);
        chk({pfx, "_c10"}, out_c10, 0);
        chk({pfx, "_c11"}, out_c11, 0);
        chk({pfx, "_importance"}, out_importance, 0);
    endtask

    task automatic chk_out(input int r, input int c, input int a [4], input int imp);
        chk("out_valid", out_valid, 1);
        chk("out_busy", busy, 1);
        chk("out_row", out_row, r);
        chk("out_col", out_col, c);
        chk("out_c00", out_c00, a[0]);
        chk("out_c01", out_c01, a[1]);
        chk("out_c10", out_c10, a[2]);
        chk("out_c11", out_c11, a[3]);
        chk("out_importance", out_importance, imp);
    endtask

    // One job. abort_tile/reset_tile select a tile to cut short (-1 = none).
    task automatic run_job(input bit imp, input int mode, input int abort_tile,
                           input int reset_tile, input bit start_with_abort);
        int acc [4];
        int res [4];
        int exp_imp, imp_val, n, hold, r, c;
        cal_importance = imp;
        start = 1'b1;
        abort = start_with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        cal_importance = ~imp;
        chk("busy_after_start", busy, 1);
        for (int t = 0; t < M_TILES * N_TILES; t++) begin
            r = t / N_TILES;
            c = t % N_TILES;
            acc = '{0, 0, 0, 0};
            exp_imp = 0;
            for (int k = 0; k < K_CHUNKS; k++) begin
                n = 0;
                while (!tile_req && n < 20) begin
                    tick();
                    n++;
                end
                chk("tile_req_seen", tile_req, 1);
                if (!tile_req) return;
                chk("tile_row", tile_row, r);
                chk("tile_col", tile_col, c);
                chk("tile_k", tile_k, k);
                chk("req_sa_enable", sa_enable, 0);
                tile_ack = 1'b1;
                sa_done = 1'b1;
                sa_result0 = RW'($urandom);
                sa_result1 = RW'($urandom);
                sa_result2 = RW'($urandom);
                sa_result3 = RW'($urandom);
                tick();
                tile_ack = 1'b0;
                sa_done = 1'b0;
                chk("run_tile_req", tile_req, 0);
                chk("run_sa_enable", sa_enable, 1);
                chk("run_cal_imp", sa_cal_importance, 32'(imp && k == K_CHUNKS - 1));
                if (t == abort_tile && k == 0) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk_idle("abort");
                    repeat (3) begin
                        tick();
                        chk("abort_no_done", done, 0);
                    end
                    return;
                end
                start = (k == 1);
                for (int w = 0; w < 4; w++) begin
                    tick();
                    start = 1'b0;
                    chk("run_hold_enable", sa_enable, 1);
                    chk("run_hold_cal", sa_cal_importance, 32'(imp && k == K_CHUNKS - 1));
                    chk("run_hold_k", tile_k, k);
                end
                for (int j = 0; j < 4; j++) res[j] = gen(mode, k, j);
                sa_result0 = RW'(res[0]);
                sa_result1 = RW'(res[1]);
                sa_result2 = RW'(res[2]);
                sa_result3 = RW'(res[3]);
                sa_done = 1'b1;
                sa_importance = RW'($urandom);
                tick();
                sa_done = 1'b0;
                sa_result0 = RW'($urandom);
                sa_result1 = RW'($urandom);
                sa_result2 = RW'($urandom);
                sa_result3 = RW'($urandom);
                chk("acc_sa_enable", sa_enable, 0);
                chk("acc_cal_imp", sa_cal_importance, 0);
                imp_val = int'($urandom_range(1, 65535));
                sa_importance = RW'(imp_val);
                tile_ack = 1'b1;
                if (imp && k == K_CHUNKS - 1) exp_imp = imp_val;
                for (int j = 0; j < 4; j++) acc[j] = sat(acc[j] + res[j]);
                tick();
                tile_ack = 1'b0;
                sa_importance = RW'($urandom);
            end
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("out_valid_seen", out_valid, 1);
            if (!out_valid) return;
            if (t == reset_tile) begin
                rst_n = 1'b0;
                #1;
                chk_idle("reset_async");
                #2;
                rst_n = 1'b1;
                tick();
                chk_idle("reset_after");
                return;
            end
            hold = (t == 1) ? 10 : int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                chk_out(r, c, acc, exp_imp);
                tick();
            end
            chk_out(r, c, acc, exp_imp);
            $display("tile (%0d,%0d) c=%0d,%0d,%0d,%0d imp=%0h", r, c,
                     acc[0], acc[1], acc[2], acc[3], exp_imp);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("post_xfer_valid", out_valid, 0);
            if (t < M_TILES * N_TILES - 1) chk("early_done", done, 0);
        end
        chk("done_pulse", done, 1);
        chk("fin_busy", busy, 0);
        tick();
        chk_idle("after_done");
    endtask

    initial begin
        tick();
        tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();
        chk_idle("idle");
        run_job(1'b0, 3, -1, -1, 1'b0);
        run_job(1'b1, 1, -1, -1, 1'b0);
        run_job(1'b1, 0, 1, -1, 1'b0);
        run_job(1'b0, 2, -1, 2, 1'b0);
        run_job(1'b1, 0, -1, -1, 1'b1);
        run_job(1'b0, 0, -1, -1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mini_sysarray_sched.md
Name: mini_sysarray_sched

Overview:
Tile scheduler for the 2x2-output mini systolic array. It computes C = A(M x K) x B(K x N) by walking 2x2 output tiles and, for each tile, 4-deep K chunks. For every chunk it requests operands from the operand buffer, runs the array, and accumulates the partial results. It emits one finished 2x2 tile at a time, with optional Importance, to the downstream result buffer.

Parameters:
WIDTH, 8, operand width; array results are 2*WIDTH signed
ACC_W, 20, accumulator/output width, signed, must be >= 2*WIDTH
M_TILES, 4, number of 2-row output tile rows
N_TILES, 4, number of 2-col output tile columns
K_CHUNKS, 4, number of 4-deep K chunks per tile
IDX_W, 4, width of the tile/chunk index outputs

Ports:
clk  in  1  clock, all logic on rising edge
_reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a job when IDLE, ignored otherwise
abort  in  1  synchronous; ends the job and returns to IDLE without done
cal_importance  in  1  sampled at accepted start; enables Importance for the job
busy  out  1  high from the cycle after accepted start until the return to IDLE
done  out  1  one-cycle pulse after the last tile is accepted downstream
tile_req  out  1  operand request, level
tile_row, tile_col, tile_k  out  IDX_W each  indices of the requested operands
tile_ack  in  1  one-cycle pulse; operands are on the array inputs and held stable until the next tile_req
sa_enable  out  1  array enable
sa_cal_importance  out  1  array CalImportanceFlag
sa_done  in  1  array done pulse
sa_result0..3  in  2*WIDTH each  signed array results (r0=C00, r1=C01, r2=C10, r3=C11)
sa_importance  in  2*WIDTH  array Importance output
out_valid  out  1  finished tile valid
out_ready  in  1  downstream ready
out_row, out_col  out  IDX_W each  tile indices
out_c00, out_c01, out_c10, out_c11  out  ACC_W each  accumulated tile values
out_importance  out  2*WIDTH  Importance of the tile; 0 if importance is disabled

Behaviour:
- Reset (async, _reset=0): state IDLE. All outputs 0, including busy, done, tile_req, indices, sa_enable, sa_cal_importance, out_valid, out_* and accumulators. Reset mid-operation aborts immediately with no done.
- States: IDLE, REQ, RUN, ACC, OUT, FIN.
- IDLE: on start, clear the indices and accumulators, latch cal_importance, then go to REQ.
- REQ: tile_req=1 with the current row/col/k. On tile_ack, drop tile_req and go to RUN the next cycle.
- RUN: sa_enable=1. sa_cal_importance=1 only when importance is latched and tile_k==K_CHUNKS-1. Stay until sa_done=1, which nominally arrives 5 cycles after sa_enable rises. In that same cycle, capture sa_result0..3 into holding registers and go to ACC.
- ACC (1 cycle): sa_enable=0, which resets the array counter.
  - Each accumulator takes acc + sign-extended result, saturated to the signed ACC_W range: max 2^(ACC_W-1)-1, min -2^(ACC_W-1).
  - If importance is enabled and this is the last chunk, capture sa_importance this cycle; the array registers Importance one cycle after done.
  - If tile_k < K_CHUNKS-1: increment tile_k and go to REQ. Otherwise go to OUT.
- Chunk results are treated as independent partial products. The scheduler does not rely on the array accumulating across runs.
- OUT: out_valid=1 with stable out_* until out_ready=1 (transfer when both are high). out_valid may be held any number of cycles.
  - On transfer, clear the accumulators and tile_k.
  - Advance tile_col; on wrap to 0, advance tile_row. Order is row-major: (0,0), (0,1), ..., (M_TILES-1, N_TILES-1).
  - If more tiles remain go to REQ, else go to FIN.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- abort: takes effect in any non-IDLE state at the next edge. It forces sa_enable=0, tile_req=0, out_valid=0 and clears the accumulators; no done, no further out transfer. Abort has priority over simultaneous tile_ack, sa_done or out_ready.
- start while busy: ignored. Start in the same cycle as abort in IDLE: start is accepted.
- sa_done outside RUN, and tile_ack outside REQ: ignored.
- sa_enable is never high in two consecutive chunks without an intervening low cycle (the ACC state).

Test Plan:
- Single tile, M=N=K_CHUNKS=1; results 3, -5, 7, 100 -> one out transfer with c00=3, c01=-5, c10=7, c11=100, row=col=0; done pulses one cycle later; busy returns to 0.
- K_CHUNKS=4, every chunk gives r0=1000, r3=-250 -> out_c00=4000, out_c11=-1000; tile_k sequence 0,1,2,3; sa_enable is low for exactly the ACC cycle between chunks.
- ACC_W=16, K_CHUNKS=4, r0=16000 and r1=-16000 per chunk -> c00=32767 and c01=-32768 (saturated).
- M_TILES=N_TILES=2, K_CHUNKS=1, out_ready held low for 10 cycles on the second tile -> out_* stable throughout; tile order (0,0),(0,1),(1,0),(1,1); single done pulse.
- cal_importance=1, K_CHUNKS=2 -> sa_cal_importance high only during the chunk-1 RUN; out_importance equals sa_importance sampled in ACC (e.g. 0x0123); with cal_importance=0, out_importance=0.
- abort asserted during RUN of tile (0,1), and separately _reset pulled low during OUT -> IDLE, all outputs 0, no done; a following start runs a full job correctly.
